// File: rtl/z_stream_packer.sv
// z_stream_packer
//
// Samples the single-bit z result stream on qualified cycles and packs the
// bits LSB-first into WORD_W-bit words. Each word is tagged with its bit
// count and ones count, buffered in a small FIFO, and delivered over a
// valid/ready handshake.
//
// Optional feature macro: Z_PACKER_PARITY_EN
//   When defined, each FIFO entry also carries the XOR of its valid bits,
//   presented on out_parity.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous reset, active-high
//   z_in       in   bit from the upstream combining stage
//   z_valid    in   z_in is sampled this cycle
//   flush      in   pulse: emit the pending partial word
//   out_data   out  packed word, bit 0 oldest, unfilled bits 0
//   out_len    out  number of valid bits in out_data (1..WORD_W)
//   out_ones   out  number of 1 bits in out_data
//   out_parity out  XOR of the valid bits (only with Z_PACKER_PARITY_EN)
//   out_valid  out  FIFO head is valid
//   out_ready  in   consumer accepts the head
//   overflow   out  sticky: a word was dropped on a full FIFO
//   drop_cnt   out  dropped word count, saturating at 255

module z_stream_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z_in,
    input  logic              z_valid,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic [CW-1:0]     out_len,
    output logic [CW-1:0]     out_ones,
`ifdef Z_PACKER_PARITY_EN
    output logic              out_parity,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Assembly
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] acc_q, acc_d, acc_upd;
    logic [CW-1:0]     idx_q, idx_d, idx_upd;
    logic [CW-1:0]     ones_q, ones_d, ones_upd;
    logic              complete, push;

    always_comb begin
        // Bits above idx are always 0, so OR-ing the new bit in is enough.
        acc_upd  = acc_q;
        idx_upd  = idx_q;
        ones_upd = ones_q;
        if (z_valid) begin
            acc_upd  = acc_q | (WORD_W'(z_in) << idx_q);
            idx_upd  = idx_q + CW'(1);
            ones_upd = ones_q + CW'(z_in);
        end
        complete = z_valid && (idx_q == CW'(WORD_W - 1));
        // A flush coinciding with completion sees idx_upd as the full word
        // length, so it merges into the same push rather than adding one.
        push     = complete || (flush && (idx_upd != '0));

        acc_d  = acc_upd;
        idx_d  = idx_upd;
        ones_d = ones_upd;
        if (push) begin
            acc_d  = '0;
            idx_d  = '0;
            ones_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            idx_q  <= '0;
            ones_q <= '0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            ones_q <= ones_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [CW-1:0]     mem_len  [FIFO_DEPTH];
    logic [CW-1:0]     mem_ones [FIFO_DEPTH];
`ifdef Z_PACKER_PARITY_EN
    logic              mem_par  [FIFO_DEPTH];
`endif

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          full, pop, wr_en, drop;

    always_comb begin
        full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
        pop   = (cnt_q != '0) && out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PW+1)'(wr_en) - (PW+1)'(pop);

        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= acc_upd;
            mem_len[wr_ptr_q]  <= idx_upd;
            mem_ones[wr_ptr_q] <= ones_upd;
`ifdef Z_PACKER_PARITY_EN
            mem_par[wr_ptr_q]  <= ^acc_upd;
`endif
        end
    end

    always_comb begin
        out_valid = (cnt_q != '0);
        out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
        out_len   = out_valid ? mem_len[rd_ptr_q]  : '0;
        out_ones  = out_valid ? mem_ones[rd_ptr_q] : '0;
`ifdef Z_PACKER_PARITY_EN
        out_parity = out_valid ? mem_par[rd_ptr_q] : 1'b0;
`endif
        overflow  = ovf_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_z_stream_packer.sv
// Self-checking bench for z_stream_packer (WORD_W=8, FIFO_DEPTH=4).
// A reference model of assembly and FIFO occupancy pushes expected words
// into a scoreboard queue; the head is compared every cycle it is valid.

module tb_z_stream_packer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] len;
        logic [CW-1:0] ones;
    } word_t;

    logic          clk = 1'b0;
    logic          reset, z_in, z_valid, flush, out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_len, out_ones;
    logic          out_valid, overflow;
    logic [7:0]    drop_cnt;
`ifdef Z_PACKER_PARITY_EN
    logic          out_parity;
`endif

    always #5 clk = ~clk;

    z_stream_packer #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .z_in(z_in), .z_valid(z_valid), .flush(flush),
        .out_data(out_data), .out_len(out_len), .out_ones(out_ones),
`ifdef Z_PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    word_t      exp_q[$];
    logic [W-1:0] m_acc;
    int         m_idx, m_ones, m_cnt, m_drop;
    bit         m_ovf;

    task automatic model_clear_asm();
        m_acc = '0; m_idx = 0; m_ones = 0;
    endtask

    task automatic model_push(input int len);
        word_t w;
        bit    pop_now;
        w.data = m_acc; w.len = CW'(len); w.ones = CW'(m_ones);
        pop_now = (m_cnt > 0) && out_ready;
        if (m_cnt < D || pop_now) begin
            exp_q.push_back(w);
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        model_clear_asm();
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model,
    // return at the next posedge+1.
    task automatic step(input bit zv, input bit zi, input bit fl, input bit rdy, input bit rs);
        bit pop_now;
        reset = rs; z_valid = zv; z_in = zi; flush = fl; out_ready = rdy;
        @(negedge clk);
        check_val("out_valid", {31'b0, out_valid}, {31'b0, m_cnt > 0});
        check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check_val("drop_cnt", {24'b0, drop_cnt}, m_drop);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", 32'd1, 32'd0);
            end else begin
                check_val("out_data", {24'b0, out_data}, {24'b0, exp_q[0].data});
                check_val("out_len",  {28'b0, out_len},  {28'b0, exp_q[0].len});
                check_val("out_ones", {28'b0, out_ones}, {28'b0, exp_q[0].ones});
`ifdef Z_PACKER_PARITY_EN
                check_val("out_parity", {31'b0, out_parity}, {31'b0, ^exp_q[0].data});
`endif
            end
        end
        if (rs) begin
            exp_q.delete();
            m_cnt = 0; m_drop = 0; m_ovf = 1'b0;
            model_clear_asm();
        end else begin
            pop_now = (m_cnt > 0) && rdy;
            if (zv) begin
                m_acc[m_idx] = zi;
                m_ones += int'(zi);
                m_idx++;
            end
            if (m_idx == W)            model_push(W);
            else if (fl && m_idx > 0)  model_push(m_idx);
            if (pop_now) begin
                void'(exp_q.pop_front());
                m_cnt--;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
    endtask

    task automatic send_word(input logic [W-1:0] b, input bit rdy);
        for (int i = 0; i < W; i++) step(1, b[i], 0, rdy, 0);
    endtask

    initial begin
        logic [W-1:0] pat;
        reset = 1'b1; z_in = 0; z_valid = 0; flush = 0; out_ready = 0;
        m_cnt = 0; m_drop = 0; m_ovf = 0; model_clear_asm();
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_val("rst_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_data",  {24'b0, out_data}, 32'd0);
        check_val("rst_len",   {28'b0, out_len},  32'd0);
        check_val("rst_ones",  {28'b0, out_ones}, 32'd0);
        check_val("rst_drop",  {24'b0, drop_cnt}, 32'd0);

        // Full word 1,0,1,1,0,0,0,1 -> 8'h8D
        pat = 8'b1000_1101;
        send_word(pat, 1);
        check_val("w1_valid", {31'b0, out_valid}, 32'd1);
        check_val("w1_data",  {24'b0, out_data}, 32'h8D);
        check_val("w1_len",   {28'b0, out_len},  32'd8);
        check_val("w1_ones",  {28'b0, out_ones}, 32'd4);
        idle(3, 1);

        // Partial word 1,1,0 + flush -> 8'h03, len 3; second flush: nothing
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check_val("p_data", {24'b0, out_data}, 32'h03);
        check_val("p_len",  {28'b0, out_len},  32'd3);
        check_val("p_ones", {28'b0, out_ones}, 32'd2);
        step(0, 0, 1, 1, 0);
        idle(3, 1);

        // Backpressure: 5 words into a 4-deep FIFO, 5th dropped
        for (int k = 0; k < 5; k++) send_word(W'($urandom), 0);
        check_val("bp_overflow", {31'b0, overflow}, 32'd1);
        check_val("bp_drop",     {24'b0, drop_cnt}, 32'd1);
        idle(6, 1);

        // Full FIFO, 5th word completes on a pop edge: no drop
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) send_word(W'($urandom), 0);
        pat = W'($urandom);
        for (int i = 0; i < W - 1; i++) step(1, pat[i], 0, 0, 0);
        step(1, pat[W-1], 0, 1, 0);
        check_val("same_pop_ovf", {31'b0, overflow}, 32'd0);
        idle(6, 1);
        check_val("same_pop_drain", exp_q.size(), 32'd0);

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        check_val("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check_val("mid_rst_drop",  {24'b0, drop_cnt}, 32'd0);
        send_word(8'h5A, 1);
        check_val("mid_rst_len",  {28'b0, out_len},  32'd8);
        check_val("mid_rst_data", {24'b0, out_data}, 32'h5A);
        idle(2, 1);

        // Flush with the 8th bit: one word only
        pat = 8'hC3;
        for (int i = 0; i < W - 1; i++) step(1, pat[i], 0, 1, 0);
        step(1, pat[W-1], 1, 1, 0);
        check_val("fl8_len", {28'b0, out_len}, 32'd8);
        idle(3, 1);

        // Random traffic with random backpressure and flushes
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, 0);
        idle(8, 1);
        check_val("final_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
